// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback,
// drives every datapath select and write enable, and counts retired instructions.
`timescale 1ns/1ps
module multicycle_control_fsm #(
  parameter int CNT_W       = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  RTEX   = 4'd7,
    RTWB   = 4'd8,  BEQEX  = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    JEX    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  logic   rdy;

  assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state = state_q;

  // Next-state and retire counter. Leaving a final state for FETCH retires one instruction.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_count <= '0;
    end else begin
      case (state_q)
        IDLE:   state_q <= FETCH;
        FETCH:  if (rdy) state_q <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state_q <= MEMADR;
            OP_RTYPE:     state_q <= RTEX;
            OP_BEQ:       state_q <= BEQEX;
            OP_ADDI:      state_q <= ADDIEX;
            OP_J:         state_q <= JEX;
            default:      state_q <= FETCH;
          endcase
        end
        MEMADR: state_q <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (rdy) state_q <= MEMWB;
        MEMWR: begin
          if (rdy) begin
            state_q     <= FETCH;
            instr_count <= instr_count + CNT_W'(1);
          end
        end
        RTEX:   state_q <= RTWB;
        ADDIEX: state_q <= ADDIWB;
        MEMWB, RTWB, BEQEX, ADDIWB, JEX: begin
          state_q     <= FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore decode of the current state; FETCH writes are additionally gated by the memory handshake.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_en     = rdy;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
          default:                                       illegal_op = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      RTWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      ADDIWB: reg_write = 1'b1;
      JEX: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver queues hand-written expectations per cycle,
// a monitor on the falling edge pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

  localparam int CNT_W = 4;

  // Control vector order: iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
  //                       alu_src_b[1:0],alu_op[1:0],pc_src[1:0],pc_en,illegal_op
  localparam logic [14:0] C_IDLE   = 15'b0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] C_FETCH  = 15'b0_0_1_0_0_0_0_01_00_00_1_0;
  localparam logic [14:0] C_FWAIT  = 15'b0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [14:0] C_DEC    = 15'b0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [14:0] C_DECILL = 15'b0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [14:0] C_MEMADR = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [14:0] C_MEMRD  = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] C_MEMWB  = 15'b0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [14:0] C_MEMWR  = 15'b1_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] C_RTEX   = 15'b0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [14:0] C_RTWB   = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [14:0] C_BEQT   = 15'b0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [14:0] C_BEQN   = 15'b0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [14:0] C_ADDIWB = 15'b0_0_0_0_0_1_0_00_00_00_0_0;
  localparam logic [14:0] C_JEX    = 15'b0_0_0_0_0_0_0_00_00_10_1_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  typedef struct {
    string          name;
    logic [3:0]     st;
    logic [14:0]    ctrl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = 6'b0;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  logic iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [CNT_W-1:0] instr_count;
  logic [14:0] ctrl;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(CNT_W), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
    .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  assign ctrl = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                 alu_src_b, alu_op, pc_src, pc_en, illegal_op};

  task automatic check(input string name, input logic [3:0] st, input logic [14:0] c,
                       input logic [CNT_W-1:0] cnt);
    n_cmp++;
    if (state !== st || ctrl !== c || instr_count !== cnt) begin
      n_err++;
      $display("FAIL %s: got state=%0d ctrl=%b cnt=%0d, want state=%0d ctrl=%b cnt=%0d",
               name, state, ctrl, instr_count, st, c, cnt);
    end
  endtask

  // Monitor: every cycle's outputs are valid mid-cycle, so one expectation is retired per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, e.st, e.ctrl, e.cnt);
    end
  end

  task automatic step(input string name, input logic [5:0] o, input logic z, input logic r,
                      input logic [3:0] st, input logic [14:0] c, input logic [CNT_W-1:0] cnt);
    exp_t e;
    op = o;
    zero = z;
    mem_ready = r;
    e.name = name; e.st = st; e.ctrl = c; e.cnt = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want completion within 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step("reset_held", LW, 0, 1, 4'd0, C_IDLE, 4'd0);
    rst_n = 1'b1;
    step("idle_after_release", LW, 0, 1, 4'd0, C_IDLE, 4'd0);
    // lw with an instant memory, then one stalled MEMRD
    step("lw_fetch", LW, 0, 1, 4'd1, C_FETCH, 4'd0);
    step("lw_decode", LW, 0, 1, 4'd2, C_DEC, 4'd0);
    step("lw_memadr", LW, 0, 1, 4'd3, C_MEMADR, 4'd0);
    step("lw_memrd_wait", LW, 0, 0, 4'd4, C_MEMRD, 4'd0);
    step("lw_memrd", LW, 0, 1, 4'd4, C_MEMRD, 4'd0);
    step("lw_memwb", LW, 0, 1, 4'd5, C_MEMWB, 4'd0);
    // FETCH stall for three cycles
    for (int i = 0; i < 3; i++) step("fetch_wait", BEQ, 0, 0, 4'd1, C_FWAIT, 4'd1);
    step("fetch_go", BEQ, 0, 1, 4'd1, C_FETCH, 4'd1);
    step("beq_decode", BEQ, 1, 1, 4'd2, C_DEC, 4'd1);
    step("beq_taken", BEQ, 1, 1, 4'd9, C_BEQT, 4'd1);
    step("fetch2", BEQ, 0, 1, 4'd1, C_FETCH, 4'd2);
    step("beq2_decode", BEQ, 0, 1, 4'd2, C_DEC, 4'd2);
    step("beq_not_taken", BEQ, 0, 1, 4'd9, C_BEQN, 4'd2);
    step("fetch3", BAD, 0, 1, 4'd1, C_FETCH, 4'd3);
    step("illegal_decode", BAD, 0, 1, 4'd2, C_DECILL, 4'd3);
    step("illegal_to_fetch", RT, 0, 1, 4'd1, C_FETCH, 4'd3);
    step("rt_decode", RT, 0, 1, 4'd2, C_DEC, 4'd3);
    step("rt_ex", RT, 0, 1, 4'd7, C_RTEX, 4'd3);
    step("rt_wb", RT, 0, 1, 4'd8, C_RTWB, 4'd3);
    step("fetch4", ADDI, 0, 1, 4'd1, C_FETCH, 4'd4);
    step("addi_decode", ADDI, 0, 1, 4'd2, C_DEC, 4'd4);
    step("addi_ex", ADDI, 0, 1, 4'd10, C_MEMADR, 4'd4);
    step("addi_wb", ADDI, 0, 1, 4'd11, C_ADDIWB, 4'd4);
    step("fetch5", SW, 0, 1, 4'd1, C_FETCH, 4'd5);
    step("sw_decode", SW, 0, 1, 4'd2, C_DEC, 4'd5);
    step("sw_memadr", SW, 0, 1, 4'd3, C_MEMADR, 4'd5);
    step("sw_memwr_wait", SW, 0, 0, 4'd6, C_MEMWR, 4'd5);
    step("sw_memwr", SW, 0, 1, 4'd6, C_MEMWR, 4'd5);
    step("fetch6", SW, 0, 1, 4'd1, C_FETCH, 4'd6);
    step("sw2_decode", SW, 0, 1, 4'd2, C_DEC, 4'd6);
    step("sw2_memadr", SW, 0, 1, 4'd3, C_MEMADR, 4'd6);
    step("sw2_memwr_wait", SW, 0, 0, 4'd6, C_MEMWR, 4'd6);
    // Reset asserted mid-MEMWR, between clock edges
    rst_n = 1'b0;
    step("abort_memwr", SW, 0, 0, 4'd0, C_IDLE, 4'd0);
    rst_n = 1'b1;
    step("idle_again", JMP, 0, 1, 4'd0, C_IDLE, 4'd0);
    // Sixteen jumps wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) begin
      logic [CNT_W-1:0] c;
      c = CNT_W'(i);
      step("j_fetch", JMP, 0, 1, 4'd1, C_FETCH, c);
      step("j_decode", JMP, 0, 1, 4'd2, C_DEC, c);
      step("j_ex", JMP, 0, 1, 4'd12, C_JEX, c);
    end
    step("wrap_fetch", JMP, 0, 1, 4'd1, C_FETCH, 4'd0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
